escritor_timer_rtc: RTL

Write sequencer that pushes the stopwatch (cronómetro) seconds, minutes and hours registers out to the external RTC timer registers over the RTC's multiplexed address/data bus. It sits between the stopwatch register bank, which holds the BCD values captured from the decoder, and the RTC bus pins. It is the write-side counterpart of the register-load path. On one `start` pulse it snapshots the three bytes and performs three complete bus write transactions: seconds, then minutes, then hours.

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/contador_fase.sv | 35 +++
 rtl/escritor_timer_rtc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC timer-register write sequencer.
package rtc_pkg;

    localparam int PHASE_W = 8;

    localparam logic [7:0] ADDR_SEG  = 8'h41;
    localparam logic [7:0] ADDR_MIN  = 8'h42;
    localparam logic [7:0] ADDR_HORA = 8'h43;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        DATA_LO,
        DATA_HI,
        FIN
    } estado_t;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/contador_fase.sv
// Loadable down-counter timing one bus phase; fin is high while the count is zero.
module contador_fase
    import rtc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PHASE_W-1:0] valor,
    output logic               fin
);

    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PHASE_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fin = (cnt_q == '0);

endmodule

// File: rtl/escritor_timer_rtc.sv
// Writes the stopwatch seconds, minutes and hours bytes to the RTC timer registers
// as three address/data bus transactions on a single start pulse.
module escritor_timer_rtc
    import rtc_pkg::*;
#(
    parameter int         T_PULSE   = 5,
    parameter logic [7:0] ADDR_SEG  = rtc_pkg::ADDR_SEG,
    parameter logic [7:0] ADDR_MIN  = rtc_pkg::ADDR_MIN,
    parameter logic [7:0] ADDR_HORA = rtc_pkg::ADDR_HORA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dato_seg,
    input  logic [7:0] dato_min,
    input  logic [7:0] dato_hora,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done
);

    localparam logic [PHASE_W-1:0] RECARGA = PHASE_W'(T_PULSE - 1);

    estado_t    state_q, state_d;
    idx_t       idx_q, idx_d;
    logic [7:0] seg_q, seg_d, min_q, min_d, hora_q, hora_d;
    logic       cs_n_q, cs_n_d, rd_n_q, wr_n_q, wr_n_d, ad_n_q, ad_n_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d, busy_q, busy_d, done_q, done_d;

    logic       load;
    logic       fin;
    logic [7:0] dir_siguiente;
    logic [7:0] dato_actual;

    contador_fase u_contador_fase (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .valor (RECARGA),
        .fin   (fin)
    );

    always_comb begin
        dir_siguiente = ADDR_SEG;
        case (idx_q)
            2'd0:    dir_siguiente = ADDR_MIN;
            2'd1:    dir_siguiente = ADDR_HORA;
            default: dir_siguiente = ADDR_SEG;
        endcase
    end

    always_comb begin
        dato_actual = hora_q;
        case (idx_q)
            2'd0:    dato_actual = seg_q;
            2'd1:    dato_actual = min_q;
            default: dato_actual = hora_q;
        endcase
    end

    // NOTE: every signal gets a hold/default value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seg_d    = seg_q;
        min_d    = min_q;
        hora_d   = hora_q;
        load     = 1'b0;
        cs_n_d   = cs_n_q;
        wr_n_d   = wr_n_q;
        ad_n_d   = ad_n_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Bus values are only updated on LO-state or FIN entry, so they stay stable around each strobe.
        case (state_q)
            IDLE: begin
                if (start) begin
                    seg_d    = dato_seg;
                    min_d    = dato_min;
                    hora_d   = dato_hora;
                    idx_d    = '0;
                    state_d  = ADDR_LO;
                    load     = 1'b1;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    ad_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = ADDR_SEG;
                    busy_d   = 1'b1;
                end
            end
            ADDR_LO: begin
                if (fin) begin
                    state_d = ADDR_HI;
                    load    = 1'b1;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end
            end
            ADDR_HI: begin
                if (fin) begin
                    state_d  = DATA_LO;
                    load     = 1'b1;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    ad_n_d   = 1'b1;
                    ad_out_d = dato_actual;
                end
            end
            DATA_LO: begin
                if (fin) begin
                    state_d = DATA_HI;
                    load    = 1'b1;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end
            end
            DATA_HI: begin
                if (fin) begin
                    load = 1'b1;
                    if (idx_q == 2'd2) begin
                        state_d  = FIN;
                        ad_oe_d  = 1'b0;
                        ad_out_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        state_d  = ADDR_LO;
                        cs_n_d   = 1'b0;
                        wr_n_d   = 1'b0;
                        ad_n_d   = 1'b0;
                        ad_out_d = dir_siguiente;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                load    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            seg_q    <= '0;
            min_q    <= '0;
            hora_q   <= '0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            min_q    <= min_d;
            hora_q   <= hora_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= 1'b1;
            wr_n_q   <= wr_n_d;
            ad_n_q   <= ad_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cs_n   = cs_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign ad_n   = ad_n_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
